// File: rtl/seq_mult8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_pkg
// Description : Shared definitions for the seq_mult8 sequential multiplier:
//               operand/product widths, last iteration index and the FSM
//               state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package seq_mult_pkg;

    localparam int unsigned MULT_W    = 8;
    localparam int unsigned PROD_W    = 16;
    localparam int unsigned ITER_LAST = 7;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_mult_pkg
`default_nettype wire

// File: rtl/seq_mult8_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult8_if
// Description : Operand and product valid/ready handshakes of seq_mult8.
//               master : operand producer / product consumer (testbench side)
//               slave  : the multiplier
//   in_valid/in_ready/mcand/mplier   operand pair channel
//   out_valid/out_ready/product      product channel
// Revision    : 1.0  initial release
// ============================================================================
interface seq_mult8_if;
    import seq_mult_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [MULT_W-1:0] mcand;
    logic [MULT_W-1:0] mplier;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] product;

    modport master (
        output in_valid, mcand, mplier, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, mcand, mplier, out_ready,
        output in_ready, out_valid, product
    );

endinterface : seq_mult8_if
`default_nettype wire

// File: rtl/seq_mult8_hybrid_adder.sv
`default_nettype none
// ============================================================================
// Module      : hybrid_adder
// Description : 8-bit unsigned adder. Low nibble is ripple-carry; the high
//               nibble is carry-select, precomputing both carry-in outcomes
//               and choosing with the low-nibble carry.
//   a, b    in  8  addends
//   cy_in   in  1  carry in
//   sum     out 8  a + b + cy_in (low 8 bits)
//   cy_out  out 1  carry out
// Revision    : 1.0  initial release
// ============================================================================
module hybrid_adder (
    input  wire logic [7:0] a,
    input  wire logic [7:0] b,
    input  wire logic       cy_in,
    output logic      [7:0] sum,
    output logic            cy_out
);

    logic [4:0] w_c;
    logic [4:0] w_hi0;
    logic [4:0] w_hi1;

    assign w_c[0] = cy_in;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_ripple
            assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign w_hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    assign w_hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

    assign {cy_out, sum[7:4]} = w_c[4] ? w_hi1 : w_hi0;

endmodule : hybrid_adder
`default_nettype wire

// File: rtl/seq_mult8.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult8
// Description : Sequential 8x8 unsigned shift-and-add multiplier, 16-bit
//               product. One partial-product accumulation per cycle through
//               hybrid_adder; 8 iterations per operand pair.
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   bus        slave modport of seq_mult8_if (operand / product handshakes)
// Optional    : SEQ_MULT_ZERO_SKIP_EN - a zero operand at accept jumps
//               straight to DONE with product 0 (latency 1 instead of 9).
// Revision    : 1.0  initial release
// ============================================================================
module seq_mult8
    import seq_mult_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst_n,
    seq_mult8_if.slave bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [MULT_W-1:0] r_m;
    logic [MULT_W-1:0] r_acc;
    logic [MULT_W-1:0] r_q;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_zero;
    logic [MULT_W-1:0] w_b;
    logic [MULT_W-1:0] w_sum;
    logic              w_cy;

    // Partial product: add the multiplicand only when the current LSB of Q is set.
    assign w_b = r_q[0] ? r_m : '0;

    hybrid_adder u_adder (
        .a      (r_acc),
        .b      (w_b),
        .cy_in  (1'b0),
        .sum    (w_sum),
        .cy_out (w_cy)
    );

`ifdef SEQ_MULT_ZERO_SKIP_EN
    assign w_zero = (bus.mcand == '0) || (bus.mplier == '0);
`else
    assign w_zero = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs decode from the registered state only.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = w_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == CNT_W'(ITER_LAST)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_m   <= bus.mcand;
            r_acc <= '0;
            // On a zero skip Q is cleared so {ACC,Q} already reads as 0 in DONE.
            r_q   <= w_zero ? '0 : bus.mplier;
            r_cnt <= '0;
        end else if (r_state == CALC) begin
            // {cy_out, sum, Q} >> 1, keeping the low 16 bits: carry lands in ACC[7].
            {r_acc, r_q} <= {w_cy, w_sum, r_q[MULT_W-1:1]};
            r_cnt        <= r_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.product   = (r_state == DONE) ? {r_acc, r_q} : '0;

endmodule : seq_mult8
`default_nettype wire

// File: tb/tb_seq_mult8.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seq_mult8
// Description : Scoreboard testbench for seq_mult8. The driver pushes the
//               expected product and latency at each accept; a monitor pops
//               and compares whenever the product is presented.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_mult8;
    import seq_mult_pkg::*;

    typedef struct {
        logic [15:0] prod;
        int          acc_cyc;
        int          lat;
        string       name;
    } exp_t;

`ifdef SEQ_MULT_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 9;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    bit   seen = 1'b0;

    always #5 clk = ~clk;

    seq_mult8_if bus ();

    seq_mult8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: first cycle of each out_valid compares product and latency.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    check({sb[0].name, "_product"}, {16'd0, bus.product}, {16'd0, sb[0].prod});
                    check({sb[0].name, "_latency"}, cyc - sb[0].acc_cyc, sb[0].lat);
                end
            end
            if (bus.out_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                seen = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input int lat, input string name, input bit push, input bit keep,
                        output int acc);
        int   w;
        exp_t e;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!bus.in_ready) begin
            check({name, "_in_ready_timeout"}, 32'd0, 32'd1);
            acc = -1;
            return;
        end
        bus.mcand    = a;
        bus.mplier   = b;
        bus.in_valid = 1'b1;
        acc          = cyc;
        if (push) begin
            e.prod    = exp;
            e.acc_cyc = cyc;
            e.lat     = lat;
            e.name    = name;
            sb.push_back(e);
        end
        tick();
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            tick();
            w++;
        end
        if (sb.size() != 0) begin
            check({name, "_drain_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          w;
        bit          any_valid;
        int          accs[5];
        logic [7:0]  sa[5];
        logic [7:0]  sbv[5];
        logic [15:0] sp[5];

        sa  = '{8'd37, 8'd250, 8'd17, 8'd100, 8'd255};
        sbv = '{8'd91, 8'd3,   8'd17, 8'd200, 8'd1};
        sp  = '{16'h0D27, 16'h02EE, 16'h0121, 16'h4E20, 16'h00FF};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mcand     = '0;
        bus.mplier    = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_product",   {16'd0, bus.product},   32'd0);
        rst_n = 1'b1;
        tick();

        send(8'd13,  8'd11,  16'h008F, 9, "m13x11",   1'b1, 1'b0, acc); drain("m13x11");
        send(8'd255, 8'd255, 16'hFE01, 9, "m255x255", 1'b1, 1'b0, acc); drain("m255x255");
        send(8'd128, 8'd2,   16'h0100, 9, "m128x2",   1'b1, 1'b0, acc); drain("m128x2");
        send(8'd1,   8'd1,   16'h0001, 9, "m1x1",     1'b1, 1'b0, acc); drain("m1x1");
        send(8'd0,   8'd77,  16'h0000, ZERO_LAT, "m0x77", 1'b1, 1'b0, acc); drain("m0x77");

        // Back-pressure: DONE must hold with product stable and in_ready low.
        bus.out_ready = 1'b0;
        send(8'd200, 8'd150, 16'h7530, 9, "m200x150", 1'b1, 1'b0, acc);
        w = 0;
        while (!bus.out_valid && w < 30) begin
            tick();
            w++;
        end
        check("bp_reached_done", {31'd0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_hold", {14'd0, bus.out_valid, bus.in_ready, bus.product},
                  {14'd0, 1'b1, 1'b0, 16'h7530});
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
        drain("m200x150");

        // Asynchronous reset in the middle of CALC discards the operation.
        send(8'd99, 8'd99, 16'h2649, 9, "m99x99", 1'b0, 1'b0, acc);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputs", {14'd0, bus.in_ready, bus.out_valid, bus.product},
              {14'd0, 1'b1, 1'b0, 16'h0000});
        #2 rst_n = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) any_valid = 1'b1;
        end
        check("midreset_no_out_valid", {31'd0, any_valid}, 32'd0);
        send(8'd7, 8'd6, 16'h002A, 9, "m7x6", 1'b1, 1'b0, acc); drain("m7x6");

        // Streaming with in_valid and out_ready tied high.
        for (int i = 0; i < 5; i++) begin
            send(sa[i], sbv[i], sp[i], 9, $sformatf("stream%0d", i), 1'b1, 1'b1, accs[i]);
        end
        bus.in_valid = 1'b0;
        drain("stream");
        for (int i = 1; i < 5; i++) begin
            check($sformatf("stream_ii%0d", i), accs[i] - accs[i-1], 32'd10);
        end

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_seq_mult8
`default_nettype wire

// File: doc/seq_mult8.md
# seq_mult8

Sequential 8×8 unsigned shift-and-add multiplier producing a 16-bit product. Each iteration's partial-product accumulation goes through the team's existing 8-bit `hybrid_adder`. The block sits directly upstream of that adder: it drives the adder's operand and carry inputs, consumes its sum and carry-out, and presents operands and results over valid/ready handshakes.

## Interface
- No parameters. Width is fixed at 8 by `hybrid_adder`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept operands.
- `mcand`  in  8  multiplicand, unsigned.
- `mplier`  in  8  multiplier, unsigned.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  consumer accepts product.
- `product`  out  16  mcand × mplier.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - CALC: 8 iterations.
  - DONE: `out_valid`=1.
- IDLE→CALC on `in_valid && in_ready`. Capture in the same edge: M←`mcand`, ACC←0, Q←`mplier`, CNT←0.
- CALC, once per cycle:
  - The adder sees a=ACC, b=(Q[0] ? M : 0), cy_in=0.
  - Update {ACC,Q} ← {cy_out, sum, Q} >> 1, where {cy_out, sum} is 9 bits; this is a 17-bit right shift, truncated.
  - CNT increments.
  - After the iteration with CNT=7, go to DONE.
- DONE: `product`={ACC,Q}, held stable. DONE→IDLE on `out_valid && out_ready`.
- Arithmetic is unsigned throughout. The adder carry must never be dropped: 255×255 exercises it.
- `in_valid` and operand values are ignored outside IDLE.
- Reset (asynchronous, any state, including mid-CALC): state=IDLE, `in_ready`=1, `out_valid`=0, `product`=0x0000, CNT=0, M/ACC/Q=0. Any in-flight operation is discarded.

## Timing
- Accept edge = cycle 0. CALC occupies cycles 1–8. `out_valid` rises after the edge ending cycle 8 (latency 9 cycles from accept edge to `out_valid`).
- `in_ready` deasserts the cycle after accept and reasserts the cycle after the output handshake edge.
- Minimum initiation interval is 10 cycles, with `out_ready` held high.
- Back-pressure: DONE holds indefinitely while `out_ready`=0. `product` and `out_valid` do not change.
- `out_valid` never depends combinationally on `out_ready`. `in_ready` never depends combinationally on `in_valid`. Both are decoded from registered state.
- Simultaneous input and output handshake cannot occur, because `in_ready` is 0 in DONE.

## Configuration
- `SEQ_MULT_ZERO_SKIP_EN` defined:
  - If `mcand`==0 or `mplier`==0 at the accept edge, go IDLE→DONE directly with `product`=0x0000.
  - Latency is 1 cycle instead of 9.
- Undefined: every operand pair takes the full 8-iteration path with fixed latency 9. The zero-detect logic is absent.

## Structure
- Shared package `seq_mult_pkg`:
  - state enum typedef (IDLE, CALC, DONE).
  - `MULT_W`=8, `PROD_W`=16, `ITER_LAST`=7.
- One sub-module instance: `hybrid_adder` (8-bit), driven combinationally from ACC/M/Q[0]. No other hierarchy.

## Test plan
- Reset → `in_ready`=1, `out_valid`=0, `product`=0x0000. 13×11 with `out_ready`=1 → `out_valid` 9 cycles after accept, `product`=0x008F.
- 255×255 → `product`=0xFE01 (carry-out path). 128×2 → 0x0100. 1×1 → 0x0001.
- 0×77 → `product`=0x0000. Latency is 9 without `SEQ_MULT_ZERO_SKIP_EN` and 1 with it.
- 200×150 with `out_ready` held 0 for 20 cycles → `product`=0x7530 stable, `in_ready`=0 throughout. Release → handshake, then `in_ready`=1 next cycle.
- `rst_n` pulsed low at CALC cycle 4 of 99×99 → immediate IDLE, `out_valid` never asserts. A following 7×6 yields 0x002A.
- Back-to-back stream of 5 random pairs with `in_valid` and `out_ready` tied high → each product matches the reference model, initiation interval = 10 cycles.
